noc_port_arbiter: RTL and testbench

//  Shares one multisim NoC channel pair among N CPU-side stream ports.

---
 rtl/noc_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_noc_port_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter that shares one registered NoC output among N CPU-side
// request streams, and routes the single NoC response stream back by destination.
module noc_port_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = $clog2(N_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS-1:0]              req_vld,
    output logic [N_PORTS-1:0]              req_rdy,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   req_data,
    output logic                            noc_vld,
    input  logic                            noc_rdy,
    output logic [DATA_WIDTH-1:0]           noc_data,
    output logic [IDX_W-1:0]                noc_src,
    input  logic                            rsp_vld,
    output logic                            rsp_rdy,
    input  logic [DATA_WIDTH-1:0]           rsp_data,
    input  logic [IDX_W-1:0]                rsp_dst,
    output logic [N_PORTS-1:0]              cpu_rsp_vld,
    input  logic [N_PORTS-1:0]              cpu_rsp_rdy,
    output logic [DATA_WIDTH-1:0]           cpu_rsp_data,
    output logic                            rsp_drop,
    output logic                            dbg_state,
    output logic [IDX_W-1:0]                dbg_rr_ptr,
    output logic [$clog2(MAX_BURST+1)-1:0]  dbg_burst_cnt
);

    // Handshake: a beat moves on a rising edge where vld and rdy are both high;
    // vld never depends on rdy, and a presented beat is held until taken.

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    localparam int                BCW       = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W:0]    N_EXT     = (IDX_W + 1)'(N_PORTS);
    localparam logic [BCW-1:0]    BURST_MAX = BCW'(MAX_BURST);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_PORTS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [BCW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                   noc_vld_q, noc_vld_d;
    logic [DATA_WIDTH-1:0]  noc_data_q, noc_data_d;
    logic [IDX_W-1:0]       noc_src_q, noc_src_d;
    logic                   rsp_drop_q, rsp_drop_d;

    logic                   slot_free;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W:0]         cand;
    logic                   load;
    logic [IDX_W-1:0]       load_idx;
    logic                   dst_ok;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    assign slot_free = !noc_vld_q || noc_rdy;

    // First valid requester at or above rr_ptr, wrapping at N_PORTS-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!win_found && req_vld[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        req_rdy     = '0;
        load        = 1'b0;
        load_idx    = owner_q;
        case (state_q)
            IDLE: begin
                if (slot_free && win_found) begin
                    req_rdy[win_idx] = 1'b1;
                    load             = 1'b1;
                    load_idx         = win_idx;
                    owner_d          = win_idx;
                    burst_cnt_d      = BCW'(1);
                    if (MAX_BURST > 1) begin
                        state_d = OWN;
                    end else begin
                        rr_ptr_d = next_idx(win_idx);
                    end
                end
            end
            OWN: begin
                if (slot_free) begin
                    if (req_vld[owner_q]) begin
                        req_rdy[owner_q] = 1'b1;
                        load             = 1'b1;
                        load_idx         = owner_q;
                        burst_cnt_d      = burst_cnt_q + BCW'(1);
                        if (burst_cnt_q + BCW'(1) == BURST_MAX) begin
                            rr_ptr_d    = next_idx(owner_q);
                            burst_cnt_d = '0;
                            state_d     = IDLE;
                        end
                    end else begin
                        // Owner went quiet: hand back without granting this cycle.
                        rr_ptr_d    = next_idx(owner_q);
                        burst_cnt_d = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        noc_vld_d  = noc_vld_q;
        noc_data_d = noc_data_q;
        noc_src_d  = noc_src_q;
        if (slot_free) begin
            noc_vld_d = load;
            if (load) begin
                noc_data_d = req_data[int'(load_idx) * DATA_WIDTH +: DATA_WIDTH];
                noc_src_d  = load_idx;
            end
        end
    end

    // Response path is purely combinational; out-of-range destinations are
    // accepted and discarded so the NoC side never wedges.
    always_comb begin
        cpu_rsp_vld = '0;
        rsp_rdy     = 1'b1;
        dst_ok      = ({1'b0, rsp_dst} < N_EXT);
        for (int i = 0; i < N_PORTS; i++) begin
            if (rsp_dst == IDX_W'(i)) begin
                cpu_rsp_vld[i] = rsp_vld;
                rsp_rdy        = cpu_rsp_rdy[i];
            end
        end
        rsp_drop_d = rsp_vld && !dst_ok;
    end

    assign cpu_rsp_data = rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            noc_vld_q   <= 1'b0;
            noc_data_q  <= '0;
            noc_src_q   <= '0;
            rsp_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            noc_vld_q   <= noc_vld_d;
            noc_data_q  <= noc_data_d;
            noc_src_q   <= noc_src_d;
            rsp_drop_q  <= rsp_drop_d;
        end
    end

    assign noc_vld       = noc_vld_q;
    assign noc_data      = noc_data_q;
    assign noc_src       = noc_src_q;
    assign rsp_drop      = rsp_drop_q;
    assign dbg_state     = state_q;
    assign dbg_rr_ptr    = rr_ptr_q;
    assign dbg_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: directed scenarios plus a random
// traffic run scored against per-port expected queues.
module tb_noc_port_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int BPP = 2500;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_vld;
    logic [N-1:0]       req_rdy;
    logic [N*DW-1:0]    req_data;
    logic               noc_vld;
    logic               noc_rdy;
    logic [DW-1:0]      noc_data;
    logic [1:0]         noc_src;
    logic               rsp_vld;
    logic               rsp_rdy;
    logic [DW-1:0]      rsp_data;
    logic [1:0]         rsp_dst;
    logic [N-1:0]       cpu_rsp_vld;
    logic [N-1:0]       cpu_rsp_rdy;
    logic [DW-1:0]      cpu_rsp_data;
    logic               rsp_drop;
    logic               dbg_state;
    logic [1:0]         dbg_rr_ptr;
    logic [2:0]         dbg_burst_cnt;

    logic [2:0]         req_vld3;
    logic [2:0]         req_rdy3;
    logic [3*DW-1:0]    req_data3;
    logic               noc_vld3;
    logic               noc_rdy3;
    logic [DW-1:0]      noc_data3;
    logic [1:0]         noc_src3;
    logic               rsp_vld3;
    logic               rsp_rdy3;
    logic [DW-1:0]      rsp_data3;
    logic [1:0]         rsp_dst3;
    logic [2:0]         cpu_rsp_vld3;
    logic [2:0]         cpu_rsp_rdy3;
    logic [DW-1:0]      cpu_rsp_data3;
    logic               rsp_drop3;
    logic               dbg_state3;
    logic [1:0]         dbg_rr_ptr3;
    logic [2:0]         dbg_burst_cnt3;

    logic [DW-1:0]      exp_q[N][$];
    logic [1:0]         exp_src_q[$];
    int                 n_pass = 0;
    int                 n_total = 0;

    noc_port_arbiter #(.N_PORTS(4), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
        .noc_vld(noc_vld), .noc_rdy(noc_rdy), .noc_data(noc_data), .noc_src(noc_src),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_dst(rsp_dst),
        .cpu_rsp_vld(cpu_rsp_vld), .cpu_rsp_rdy(cpu_rsp_rdy), .cpu_rsp_data(cpu_rsp_data),
        .rsp_drop(rsp_drop), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr),
        .dbg_burst_cnt(dbg_burst_cnt)
    );

    noc_port_arbiter #(.N_PORTS(3), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld3), .req_rdy(req_rdy3), .req_data(req_data3),
        .noc_vld(noc_vld3), .noc_rdy(noc_rdy3), .noc_data(noc_data3), .noc_src(noc_src3),
        .rsp_vld(rsp_vld3), .rsp_rdy(rsp_rdy3), .rsp_data(rsp_data3), .rsp_dst(rsp_dst3),
        .cpu_rsp_vld(cpu_rsp_vld3), .cpu_rsp_rdy(cpu_rsp_rdy3), .cpu_rsp_data(cpu_rsp_data3),
        .rsp_drop(rsp_drop3), .dbg_state(dbg_state3), .dbg_rr_ptr(dbg_rr_ptr3),
        .dbg_burst_cnt(dbg_burst_cnt3)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input int port, input int seq);
        return {8'(port), 24'h0, 32'(seq)};
    endfunction

    task automatic apply_reset();
        rst_n        = 1'b0;
        req_vld      = '0;
        req_data     = '0;
        noc_rdy      = 1'b0;
        rsp_vld      = 1'b0;
        rsp_data     = '0;
        rsp_dst      = '0;
        cpu_rsp_rdy  = '0;
        req_vld3     = '0;
        req_data3    = '0;
        noc_rdy3     = 1'b0;
        rsp_vld3     = 1'b0;
        rsp_data3    = '0;
        rsp_dst3     = '0;
        cpu_rsp_rdy3 = '0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        exp_src_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({noc_vld, noc_data, noc_src, rsp_drop} !== {1'b0, 64'h0, 2'd0, 1'b0})
            $display("FAIL reset_outputs: got vld=%b data=%h src=%0d drop=%b, want 0", noc_vld, noc_data, noc_src, rsp_drop);
        else n_pass++;
        n_total++;
        if ({dbg_state, dbg_rr_ptr, dbg_burst_cnt} !== 6'd0)
            $display("FAIL reset_state: got state=%b rr=%0d cnt=%0d, want 0", dbg_state, dbg_rr_ptr, dbg_burst_cnt);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        req_vld = 4'b0100;
        req_data[2*DW +: DW] = 64'hA5;
        noc_rdy = 1'b1;
        #1;
        n_total++;
        if (req_rdy !== 4'b0100) $display("FAIL single_grant: req_rdy=%b want 0100", req_rdy);
        else n_pass++;
        @(negedge clk);
        req_vld = 4'b1000;
        #1;
        n_total++;
        if ({noc_vld, noc_data, noc_src} !== {1'b1, 64'hA5, 2'd2})
            $display("FAIL single_out: vld=%b data=%h src=%0d want 1/a5/2", noc_vld, noc_data, noc_src);
        else n_pass++;
        n_total++;
        if (req_rdy !== 4'b0000) $display("FAIL release_no_grant: req_rdy=%b want 0000", req_rdy);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({dbg_rr_ptr, dbg_state, noc_vld} !== {2'd3, 1'b0, 1'b0})
            $display("FAIL single_release: rr=%0d state=%b vld=%b want 3/0/0", dbg_rr_ptr, dbg_state, noc_vld);
        else n_pass++;
        n_total++;
        if (req_rdy !== 4'b1000) $display("FAIL rr_from_ptr: req_rdy=%b want 1000", req_rdy);
        else n_pass++;
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_burst_order();
        logic [N-1:0] taken;
        int           seq[N];
        int           beats;
        logic [DW-1:0] e;
        logic [1:0]   es;
        apply_reset();
        for (int k = 0; k < 20; k++) exp_src_q.push_back(2'((k / 4) % 4));
        taken = '0;
        beats = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        noc_rdy = 1'b1;
        for (int cyc = 0; cyc < 80 && beats < 20; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (taken[i] || !req_vld[i]) begin
                    e = mk(i, seq[i]);
                    req_data[i*DW +: DW] = e;
                    exp_q[i].push_back(e);
                    seq[i]++;
                    req_vld[i] = 1'b1;
                end
            end
            #1;
            taken = req_vld & req_rdy;
            if (noc_vld && noc_rdy) begin
                es = exp_src_q.pop_front();
                n_total++;
                if (noc_src !== es) $display("FAIL burst_src beat %0d: src=%0d want %0d", beats, noc_src, es);
                else n_pass++;
                e = exp_q[es].pop_front();
                n_total++;
                if (noc_data !== e) $display("FAIL burst_data beat %0d: data=%h want %h", beats, noc_data, e);
                else n_pass++;
                beats++;
            end
        end
        n_total++;
        if (beats != 20) $display("FAIL burst_timeout: beats=%0d want 20", beats);
        else n_pass++;
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_backpressure();
        logic         taken;
        int           seq;
        int           got;
        logic [DW-1:0] e;
        apply_reset();
        taken = 1'b0;
        seq = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (taken) req_vld[0] = 1'b0;
            if (!req_vld[0] && seq < 6) begin
                e = mk(0, seq);
                req_data[0 +: DW] = e;
                exp_q[0].push_back(e);
                seq++;
                req_vld[0] = 1'b1;
            end
            noc_rdy = !(cyc >= 2 && cyc <= 6);
            #1;
            taken = req_vld[0] & req_rdy[0];
            if (cyc == 2) begin
                n_total++;
                if (dbg_burst_cnt !== 3'd2) $display("FAIL stall_cnt: burst_cnt=%0d want 2", dbg_burst_cnt);
                else n_pass++;
            end
            if (cyc >= 2 && cyc <= 6) begin
                n_total++;
                if ({noc_vld, noc_data, noc_src, req_rdy} !== {1'b1, mk(0, 1), 2'd0, 4'b0000})
                    $display("FAIL stall_hold cyc %0d: vld=%b data=%h src=%0d rdy=%b", cyc, noc_vld, noc_data, noc_src, req_rdy);
                else n_pass++;
            end
            if (noc_vld && noc_rdy) begin
                n_total++;
                if (exp_q[0].size() == 0) $display("FAIL bp_extra: data=%h want none", noc_data);
                else begin
                    e = exp_q[0].pop_front();
                    if (noc_data !== e || noc_src !== 2'd0)
                        $display("FAIL bp_data: data=%h src=%0d want %h src 0", noc_data, noc_src, e);
                    else n_pass++;
                end
                got++;
            end
        end
        n_total++;
        if (got != 6 || exp_q[0].size() != 0) $display("FAIL bp_count: got=%0d left=%0d want 6/0", got, exp_q[0].size());
        else n_pass++;
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_routing();
        logic [N-1:0]  ev;
        logic          er;
        logic [DW-1:0] d;
        apply_reset();
        @(negedge clk);
        rsp_vld = 1'b1;
        rsp_dst = 2'd1;
        cpu_rsp_rdy = 4'b0010;
        d = {$urandom, $urandom};
        rsp_data = d;
        #1;
        n_total++;
        if ({cpu_rsp_vld, rsp_rdy, cpu_rsp_data} !== {4'b0010, 1'b1, d})
            $display("FAIL route_dst1: vld=%b rdy=%b data=%h want 0010/1/%h", cpu_rsp_vld, rsp_rdy, cpu_rsp_data, d);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rsp_dst = 2'(k % 4);
            cpu_rsp_rdy = 4'($urandom_range(0, 15));
            ev = 4'b0001 << rsp_dst;
            er = cpu_rsp_rdy[rsp_dst];
            #1;
            n_total++;
            if ({cpu_rsp_vld, rsp_rdy} !== {ev, er})
                $display("FAIL route_loop %0d: vld=%b rdy=%b want %b/%b", k, cpu_rsp_vld, rsp_rdy, ev, er);
            else n_pass++;
        end
        @(negedge clk);
        rsp_vld = 1'b0;
        rsp_vld3 = 1'b1;
        rsp_dst3 = 2'd2;
        cpu_rsp_rdy3 = 3'b100;
        #1;
        n_total++;
        if ({cpu_rsp_vld3, rsp_rdy3, rsp_drop3} !== {3'b100, 1'b1, 1'b0})
            $display("FAIL route3_dst2: vld=%b rdy=%b drop=%b want 100/1/0", cpu_rsp_vld3, rsp_rdy3, rsp_drop3);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (rsp_drop3 !== 1'b0) $display("FAIL drop_valid_dst: drop=%b want 0", rsp_drop3);
        else n_pass++;
        rsp_dst3 = 2'd3;
        cpu_rsp_rdy3 = 3'b000;
        #1;
        n_total++;
        if ({cpu_rsp_vld3, rsp_rdy3} !== {3'b000, 1'b1})
            $display("FAIL route3_oob: vld=%b rdy=%b want 000/1", cpu_rsp_vld3, rsp_rdy3);
        else n_pass++;
        @(negedge clk);
        rsp_vld3 = 1'b0;
        #1;
        n_total++;
        if (rsp_drop3 !== 1'b1) $display("FAIL drop_pulse: drop=%b want 1", rsp_drop3);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (rsp_drop3 !== 1'b0) $display("FAIL drop_once: drop=%b want 0", rsp_drop3);
        else n_pass++;
    endtask

    task automatic test_reset_mid_beat();
        apply_reset();
        @(negedge clk);
        req_vld = 4'b0100;
        req_data[2*DW +: DW] = mk(2, 7);
        noc_rdy = 1'b1;
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        req_vld = 4'b0100;
        noc_rdy = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if ({noc_vld, dbg_rr_ptr} !== {1'b1, 2'd3})
            $display("FAIL pre_reset: vld=%b rr=%0d want 1/3", noc_vld, dbg_rr_ptr);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({noc_vld, noc_data, dbg_state, dbg_rr_ptr, dbg_burst_cnt} !== {1'b0, 64'h0, 1'b0, 2'd0, 3'd0})
            $display("FAIL async_reset: vld=%b data=%h state=%b rr=%0d cnt=%0d want all 0",
                     noc_vld, noc_data, dbg_state, dbg_rr_ptr, dbg_burst_cnt);
        else n_pass++;
        req_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_vld = 4'b1010;
        req_data[1*DW +: DW] = mk(1, 0);
        req_data[3*DW +: DW] = mk(3, 0);
        noc_rdy = 1'b1;
        #1;
        n_total++;
        if (req_rdy !== 4'b0010) $display("FAIL post_reset_grant: req_rdy=%b want 0010", req_rdy);
        else n_pass++;
        @(negedge clk);
        req_vld = 4'b1000;
        #1;
        n_total++;
        if ({noc_vld, noc_src, noc_data} !== {1'b1, 2'd1, mk(1, 0)})
            $display("FAIL post_reset_beat: vld=%b src=%0d data=%h want 1/1/%h", noc_vld, noc_src, noc_data, mk(1, 0));
        else n_pass++;
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_random();
        int            sent[N];
        logic [N-1:0]  taken;
        int            delivered;
        int            cyc;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        logic [N-1:0]  ev;
        logic          er;
        int            left;
        apply_reset();
        for (int i = 0; i < N; i++) sent[i] = 0;
        taken = '0;
        delivered = 0;
        cyc = 0;
        while (delivered < N * BPP && cyc < 60000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (taken[i]) req_vld[i] = 1'b0;
                if (!req_vld[i] && sent[i] < BPP && $urandom_range(0, 3) != 0) begin
                    d = mk(i, sent[i]);
                    req_data[i*DW +: DW] = d;
                    exp_q[i].push_back(d);
                    sent[i]++;
                    req_vld[i] = 1'b1;
                end
            end
            noc_rdy = ($urandom_range(0, 3) != 0);
            rsp_vld = 1'($urandom_range(0, 1));
            rsp_dst = 2'($urandom_range(0, 3));
            cpu_rsp_rdy = 4'($urandom_range(0, 15));
            rsp_data = {$urandom, $urandom};
            ev = rsp_vld ? (4'b0001 << rsp_dst) : 4'b0000;
            er = cpu_rsp_rdy[rsp_dst];
            #1;
            taken = req_vld & req_rdy;
            n_total++;
            if ($countones(req_rdy) > 1 || (noc_vld && !noc_rdy && req_rdy != '0))
                $display("FAIL rdy_rule cyc %0d: req_rdy=%b noc_vld=%b noc_rdy=%b", cyc, req_rdy, noc_vld, noc_rdy);
            else n_pass++;
            n_total++;
            if ({cpu_rsp_vld, rsp_rdy, cpu_rsp_data, rsp_drop} !== {ev, er, rsp_data, 1'b0})
                $display("FAIL rnd_route cyc %0d: vld=%b rdy=%b drop=%b want %b/%b/0", cyc, cpu_rsp_vld, rsp_rdy, rsp_drop, ev, er);
            else n_pass++;
            if (noc_vld && noc_rdy) begin
                n_total++;
                if ($isunknown(noc_src) || exp_q[noc_src].size() == 0)
                    $display("FAIL rnd_unexpected: src=%0d data=%h", noc_src, noc_data);
                else begin
                    e = exp_q[noc_src].pop_front();
                    if (noc_data !== e) $display("FAIL rnd_data src %0d: data=%h want %h", noc_src, noc_data, e);
                    else n_pass++;
                end
                delivered++;
            end
            cyc++;
        end
        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        n_total++;
        if (delivered != N * BPP || left != 0)
            $display("FAIL rnd_complete: delivered=%0d left=%0d want %0d/0", delivered, left, N * BPP);
        else n_pass++;
        @(negedge clk);
        req_vld = '0;
        rsp_vld = 1'b0;
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_single();
        test_burst_order();
        test_backpressure();
        test_routing();
        test_reset_mid_beat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
